// File: rtl/seq_pkg.sv
// Shared definitions for the 1101 link: one-hot FSM encodings and the
// default pattern that the detector end also uses.
// No ports (package).
package seq_pkg;

    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_SEND = 4'b0010,
        ST_GAP  = 4'b0100,
        ST_DONE = 4'b1000
    } state_t;

    localparam logic [3:0] PAT_1101 = 4'b1101;

    localparam int PW_DEF = 4;
    localparam int CW_DEF = 4;
    localparam int GW_DEF = 3;

endpackage

// File: rtl/sequence_generator_1101_if.sv
// Job/handshake bundle between a job source and the pattern transmitter.
//   start      source -> tx  request a transmission
//   pattern_i  source -> tx  pattern, MSB sent first
//   count_i    source -> tx  repetition count
//   gap_i      source -> tx  idle cycles between repetitions
//   out        tx -> source  serial bit
//   out_valid  tx -> source  out carries a pattern bit
//   busy       tx -> source  transmission in progress
//   done       tx -> source  one-cycle pulse after the final bit
interface sequence_generator_1101_if #(
    parameter int PW = 4,
    parameter int CW = 4,
    parameter int GW = 3
);
    logic          start;
    logic [PW-1:0] pattern_i;
    logic [CW-1:0] count_i;
    logic [GW-1:0] gap_i;
    logic          out;
    logic          out_valid;
    logic          busy;
    logic          done;

    modport master (
        output start, pattern_i, count_i, gap_i,
        input  out, out_valid, busy, done
    );

    modport slave (
        input  start, pattern_i, count_i, gap_i,
        output out, out_valid, busy, done
    );
endinterface

// File: rtl/piso_shift.sv
// Parallel-in serial-out register, MSB first.
//   clk    rising-edge clock
//   rst    asynchronous active-high reset, clears the register
//   load   capture d (has priority over shift)
//   shift  shift left by one, zero filling from the LSB
//   d      parallel load value
//   msb    current MSB (flop output)
module piso_shift #(
    parameter int PW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          shift,
    input  logic [PW-1:0] d,
    output logic          msb
);

    logic [PW-1:0] sr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q <= '0;
        end else if (load) begin
            sr_q <= d;
        end else if (shift) begin
            sr_q <= {sr_q[PW-2:0], 1'b0};
        end
    end

    assign msb = sr_q[PW-1];

endmodule

// File: rtl/sequence_generator_1101.sv
// Serial pattern transmitter feeding the 1101 detector's serial input.
// Latches pattern/count/gap on an accepted start, then shifts the pattern
// out MSB first, count times, with gap idle cycles between repetitions.
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   job interface (slave side): start, pattern_i, count_i, gap_i in;
//         out, out_valid, busy, done out
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for start, all outputs low
// SEND    | a pattern bit is on out, out_valid high
// GAP     | idle cycles between repetitions, busy still high
// DONE    | one-cycle done pulse; a start here is accepted as in IDLE
module sequence_generator_1101
    import seq_pkg::*;
#(
    parameter int PW = 4,
    parameter int CW = 4,
    parameter int GW = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    sequence_generator_1101_if.slave  bus
);

    localparam int BW = (PW > 1) ? $clog2(PW) : 1;

    state_t        state_q;
    logic [PW-1:0] pat_q;
    logic [GW-1:0] gap_q;
    logic [BW-1:0] bit_cnt;
    logic [CW-1:0] rep_cnt;
    logic [GW-1:0] gap_cnt;
    logic          out_valid_q;
    logic          busy_q;
    logic          done_q;

    logic          accept;
    logic          last_bit;
    logic          last_rep;
    logic          sr_load;
    logic          sr_shift;
    logic [PW-1:0] sr_d;
    logic          sr_msb;

    assign accept   = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && bus.start;
    assign last_bit = (bit_cnt == '0);
    assign last_rep = (rep_cnt == CW'(1));

    // The shift register is only ever reloaded at the start of a repetition;
    // after the final bit of a repetition it has shifted itself to all zeros,
    // so its MSB can drive out directly and reads 0 outside SEND.
    always_comb begin
        sr_load  = 1'b0;
        sr_shift = 1'b0;
        sr_d     = pat_q;
        if (accept) begin
            sr_load = 1'b1;
            sr_d    = (bus.count_i == '0) ? '0 : bus.pattern_i;
        end else if (state_q == ST_SEND) begin
            if (last_bit && !last_rep && (gap_q == '0)) begin
                sr_load = 1'b1;
            end else begin
                sr_shift = 1'b1;
            end
        end else if ((state_q == ST_GAP) && (gap_cnt == '0)) begin
            sr_load = 1'b1;
        end
    end

    piso_shift #(.PW(PW)) u_piso (
        .clk   (clk),
        .rst   (rst),
        .load  (sr_load),
        .shift (sr_shift),
        .d     (sr_d),
        .msb   (sr_msb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pat_q       <= '0;
            gap_q       <= '0;
            bit_cnt     <= '0;
            rep_cnt     <= '0;
            gap_cnt     <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        pat_q   <= bus.pattern_i;
                        gap_q   <= bus.gap_i;
                        bit_cnt <= BW'(PW - 1);
                        rep_cnt <= bus.count_i;
                        if (bus.count_i == '0) begin
                            state_q     <= ST_DONE;
                            done_q      <= 1'b1;
                            busy_q      <= 1'b0;
                            out_valid_q <= 1'b0;
                        end else begin
                            state_q     <= ST_SEND;
                            busy_q      <= 1'b1;
                            out_valid_q <= 1'b1;
                        end
                    end else begin
                        state_q     <= ST_IDLE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b0;
                    end
                end
                ST_SEND: begin
                    if (!last_bit) begin
                        bit_cnt <= bit_cnt - BW'(1);
                    end else begin
                        rep_cnt <= rep_cnt - CW'(1);
                        if (last_rep) begin
                            state_q     <= ST_DONE;
                            done_q      <= 1'b1;
                            busy_q      <= 1'b0;
                            out_valid_q <= 1'b0;
                        end else if (gap_q == '0) begin
                            bit_cnt <= BW'(PW - 1);
                        end else begin
                            state_q     <= ST_GAP;
                            gap_cnt     <= gap_q - GW'(1);
                            out_valid_q <= 1'b0;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == '0) begin
                        state_q     <= ST_SEND;
                        bit_cnt     <= BW'(PW - 1);
                        out_valid_q <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    busy_q      <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out       = sr_msb;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_sequence_generator_1101.sv
module tb_sequence_generator_1101;
    import seq_pkg::*;

    localparam int PW = 4;
    localparam int CW = 4;
    localparam int GW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sequence_generator_1101_if #(.PW(PW), .CW(CW), .GW(GW)) bus ();

    sequence_generator_1101 #(.PW(PW), .CW(CW), .GW(GW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Expected per-cycle outputs packed as {out, out_valid, busy, done}.
    logic [3:0] exp_q[$];

    function automatic logic [3:0] obs();
        return {bus.out, bus.out_valid, bus.busy, bus.done};
    endfunction

    // Reference model: the serial stream a job produces, cycle by cycle,
    // starting at the cycle after the accepted start.
    task automatic build_expected(input logic [PW-1:0] pat, input int cnt, input int gap);
        for (int r = 0; r < cnt; r++) begin
            for (int b = PW - 1; b >= 0; b--) exp_q.push_back({pat[b], 1'b1, 1'b1, 1'b0});
            if (r < cnt - 1)
                for (int g = 0; g < gap; g++) exp_q.push_back(4'b0010);
        end
        exp_q.push_back(4'b0001);
    endtask

    task automatic drive_start(input logic [PW-1:0] pat, input int cnt, input int gap);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.pattern_i = pat;
        bus.count_i   = CW'(cnt);
        bus.gap_i     = GW'(gap);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0; bus.pattern_i = '0; bus.count_i = '0; bus.gap_i = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (obs() !== 4'b0000) begin
            failures++;
            $display("FAIL reset_hold got %b need 0000", obs());
        end
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (obs() !== 4'b0000) begin
                failures++;
                $display("FAIL reset_idle got %b need 0000", obs());
            end
        end
    endtask

    task automatic test_single();
        exp_q.delete();
        build_expected(PAT_1101, 1, 0);
        exp_q.push_back(4'b0000);
        exp_q.push_back(4'b0000);
        drive_start(PAT_1101, 1, 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            if (i == 0) bus.start = 1'b0;
            checks++;
            if (obs() !== exp_q[i]) begin
                failures++;
                $display("FAIL single cycle t+%0d got %b need %b", i + 1, obs(), exp_q[i]);
            end
        end
    endtask

    task automatic test_repeat_gap();
        logic [3:0] hist;
        int pulses;
        int done_at;
        hist = '0; pulses = 0; done_at = -1;
        exp_q.delete();
        build_expected(PAT_1101, 3, 2);
        exp_q.push_back(4'b0000);
        drive_start(PAT_1101, 3, 2);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            if (i == 0) bus.start = 1'b0;
            hist = {hist[2:0], bus.out};
            if (hist == 4'b1101) pulses++;
            if (bus.done === 1'b1 && done_at < 0) done_at = i + 1;
            checks++;
            if (obs() !== exp_q[i]) begin
                failures++;
                $display("FAIL repeat_gap cycle t+%0d got %b need %b", i + 1, obs(), exp_q[i]);
            end
        end
        checks++;
        if (done_at != 17) begin
            failures++;
            $display("FAIL repeat_gap_done_time got t+%0d need t+17", done_at);
        end
        checks++;
        if (pulses != 3) begin
            failures++;
            $display("FAIL repeat_gap_detector_pulses got %0d need 3", pulses);
        end
    endtask

    task automatic test_zero_count();
        exp_q.delete();
        build_expected(4'b1111, 0, 3);
        exp_q.push_back(4'b0000);
        exp_q.push_back(4'b0000);
        drive_start(4'b1111, 0, 3);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            if (i == 0) bus.start = 1'b0;
            checks++;
            if (obs() !== exp_q[i]) begin
                failures++;
                $display("FAIL zero_count cycle t+%0d got %b need %b", i + 1, obs(), exp_q[i]);
            end
        end
    endtask

    task automatic test_start_while_busy();
        exp_q.delete();
        build_expected(PAT_1101, 1, 0);
        repeat (3) exp_q.push_back(4'b0000);
        drive_start(PAT_1101, 1, 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            if (i == 0) bus.start = 1'b0;
            checks++;
            if (obs() !== exp_q[i]) begin
                failures++;
                $display("FAIL start_while_busy cycle t+%0d got %b need %b", i + 1, obs(), exp_q[i]);
            end
            if (i == 1) begin
                bus.start = 1'b1; bus.pattern_i = 4'b0110; bus.count_i = 4'd5; bus.gap_i = 3'd3;
            end
            if (i == 2) bus.start = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        exp_q.delete();
        build_expected(PAT_1101, 1, 0);
        build_expected(4'b1011, 1, 0);
        exp_q.push_back(4'b0000);
        drive_start(PAT_1101, 1, 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            if (i == 0 || i == 5) bus.start = 1'b0;
            checks++;
            if (obs() !== exp_q[i]) begin
                failures++;
                $display("FAIL back_to_back cycle t+%0d got %b need %b", i + 1, obs(), exp_q[i]);
            end
            if (i == 4) begin
                bus.start = 1'b1; bus.pattern_i = 4'b1011; bus.count_i = 4'd1; bus.gap_i = 3'd0;
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_q.delete();
        build_expected(PAT_1101, 3, 2);
        drive_start(PAT_1101, 3, 2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) bus.start = 1'b0;
            checks++;
            if (obs() !== exp_q[i]) begin
                failures++;
                $display("FAIL reset_mid_pre cycle t+%0d got %b need %b", i + 1, obs(), exp_q[i]);
            end
        end
        // Cycle t+5 is the first gap cycle: reset lands in GAP.
        #1 rst = 1'b1;
        #1;
        checks++;
        if (obs() !== 4'b0000) begin
            failures++;
            $display("FAIL reset_mid_immediate got %b need 0000", obs());
        end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (obs() !== 4'b0000) begin
                failures++;
                $display("FAIL reset_mid_hold got %b need 0000", obs());
            end
        end
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (obs() !== 4'b0000) begin
                failures++;
                $display("FAIL reset_mid_no_done got %b need 0000", obs());
            end
        end
        test_single();
    endtask

    task automatic test_random();
        logic [PW-1:0] pat;
        int cnt;
        int gap;
        for (int j = 0; j < 25; j++) begin
            pat = PW'($urandom_range(0, 15));
            cnt = $urandom_range(0, 4);
            gap = $urandom_range(0, 7);
            if (j == 0) cnt = 15;
            exp_q.delete();
            build_expected(pat, cnt, gap);
            exp_q.push_back(4'b0000);
            drive_start(pat, cnt, gap);
            for (int i = 0; i < exp_q.size(); i++) begin
                @(negedge clk);
                checks++;
                if (obs() !== exp_q[i]) begin
                    failures++;
                    $display("FAIL random job %0d (pat %b cnt %0d gap %0d) cycle t+%0d got %b need %b",
                             j, pat, cnt, gap, i + 1, obs(), exp_q[i]);
                end
                // Noise on the job inputs is only legal while the model says busy.
                if (exp_q[i][1]) begin
                    bus.start     = 1'($urandom_range(0, 1));
                    bus.pattern_i = PW'($urandom_range(0, 15));
                    bus.count_i   = CW'($urandom_range(0, 15));
                    bus.gap_i     = GW'($urandom_range(0, 7));
                end else begin
                    bus.start = 1'b0;
                end
            end
            bus.start = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_repeat_gap();
        test_zero_count();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
